train_seq3: RTL and testbench

- Training sequencer that sits directly beside the 3-in/3-out network unit. It feeds the unit's fin and bin ports and drives its fd_prop and bk_prop phase strobes. It consumes the unit's fout and control_out.
- Per sample, it runs one cycle of: accept sample → forward settle → sample fout → backward error phase → report.
- Keeps a per-epoch count of misclassified samples.

---
 rtl/train_seq3_if.sv | 36 +++
 rtl/train_seq3.sv | 183 ++++++++++++++++++
 tb/tb_train_seq3.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/train_seq3_if.sv
// Signal bundle between train_seq3, its upstream sample source and the 3-in/3-out network.
// master = sequencer side, slave = upstream/network side.
interface train_seq3_if #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned EPOCH_LEN = 16
);
    localparam int unsigned EW = $clog2(EPOCH_LEN + 1);

    logic             train_en;
    logic             sample_valid;
    logic             sample_ready;
    logic [WIDTH-1:0] sample_x;
    logic [WIDTH-1:0] sample_y;
    logic [WIDTH-1:0] fin;
    logic [WIDTH-1:0] fout;
    logic [WIDTH-1:0] bin;
    logic             fd_prop;
    logic             bk_prop;
    logic             control_in;
    logic             result_valid;
    logic [WIDTH-1:0] result_err;
    logic             epoch_done;
    logic [EW-1:0]    epoch_errors;

    modport master (
        input  train_en, sample_valid, sample_x, sample_y, fout, control_in,
        output sample_ready, fin, bin, fd_prop, bk_prop, result_valid, result_err,
               epoch_done, epoch_errors
    );

    modport slave (
        output train_en, sample_valid, sample_x, sample_y, fout, control_in,
        input  sample_ready, fin, bin, fd_prop, bk_prop, result_valid, result_err,
               epoch_done, epoch_errors
    );
endinterface

// File: rtl/train_seq3.sv
// Training sequencer for the 3-in/3-out network: accept, forward settle, backward, report.
// Optional TRAIN_SKIP_CORRECT_EN: skip the backward phase for correctly classified samples.
module train_seq3 #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned BK_CYCLES     = 8,
    parameter int unsigned EPOCH_LEN     = 16
) (
    input logic         clk_in,
    input logic         rst_in,
    train_seq3_if.master bus
);
    localparam int unsigned EW     = $clog2(EPOCH_LEN + 1);
    localparam int unsigned MaxCyc = (SETTLE_CYCLES > BK_CYCLES) ? SETTLE_CYCLES : BK_CYCLES;
    localparam int unsigned CW     = $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {StIdle, StFwd, StBwd, StReport} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] fin_q, fin_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ten_q, ten_d;
    logic [WIDTH-1:0] fout_q, fout_d;
    logic             ready_q, ready_d;
    logic             fd_q, fd_d;
    logic             bk_q, bk_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] rerr_q, rerr_d;
    logic             ed_q, ed_d;
    logic [EW-1:0]    eerr_q, eerr_d;
    logic [EW-1:0]    scnt_q, scnt_d;
    logic [EW-1:0]    ecnt_q, ecnt_d;

    logic             finish;
    logic             go_bwd;
    logic [WIDTH-1:0] err_fin;
    logic [EW-1:0]    scnt_inc;
    logic [EW-1:0]    ecnt_inc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        y_d      = y_q;
        ten_d    = ten_q;
        fout_d   = fout_q;
        ready_d  = ready_q;
        fd_d     = fd_q;
        bk_d     = bk_q;
        bin_d    = bin_q;
        rv_d     = 1'b0;
        rerr_d   = rerr_q;
        ed_d     = 1'b0;
        eerr_d   = eerr_q;
        scnt_d   = scnt_q;
        ecnt_d   = ecnt_q;
        finish   = 1'b0;
        go_bwd   = 1'b0;
        err_fin  = '0;
        scnt_inc = '0;
        ecnt_inc = '0;

        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (bus.sample_valid && ready_q) begin
                    fin_d   = bus.sample_x;
                    y_d     = bus.sample_y;
                    ten_d   = bus.train_en;
                    fd_d    = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    fd_d    = 1'b0;
                    fout_d  = bus.fout;
                    err_fin = bus.fout ^ y_q;
`ifdef TRAIN_SKIP_CORRECT_EN
                    go_bwd  = ten_q && (err_fin != '0);
`else
                    go_bwd  = ten_q;
`endif
                    if (go_bwd) begin
                        bk_d    = 1'b1;
                        bin_d   = ~(y_q ^ bus.fout);
                        cnt_d   = '0;
                        state_d = StBwd;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StBwd: begin
                if (bus.control_in || (cnt_q == CW'(BK_CYCLES - 1))) begin
                    bk_d    = 1'b0;
                    bin_d   = '1;
                    err_fin = fout_q ^ y_q;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StReport: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Result and epoch bookkeeping land on the edge that enters REPORT.
        if (finish) begin
            state_d  = StReport;
            rv_d     = 1'b1;
            rerr_d   = err_fin;
            scnt_inc = scnt_q + EW'(1);
            ecnt_inc = ecnt_q + EW'(err_fin != '0);
            if (scnt_inc == EW'(EPOCH_LEN)) begin
                ed_d   = 1'b1;
                eerr_d = ecnt_inc;
                scnt_d = '0;
                ecnt_d = '0;
            end else begin
                scnt_d = scnt_inc;
                ecnt_d = ecnt_inc;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fin_q   <= '0;
            y_q     <= '0;
            ten_q   <= 1'b0;
            fout_q  <= '0;
            ready_q <= 1'b0;
            fd_q    <= 1'b0;
            bk_q    <= 1'b0;
            bin_q   <= '1;
            rv_q    <= 1'b0;
            rerr_q  <= '0;
            ed_q    <= 1'b0;
            eerr_q  <= '0;
            scnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            y_q     <= y_d;
            ten_q   <= ten_d;
            fout_q  <= fout_d;
            ready_q <= ready_d;
            fd_q    <= fd_d;
            bk_q    <= bk_d;
            bin_q   <= bin_d;
            rv_q    <= rv_d;
            rerr_q  <= rerr_d;
            ed_q    <= ed_d;
            eerr_q  <= eerr_d;
            scnt_q  <= scnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.fin          = fin_q;
    assign bus.bin          = bin_q;
    assign bus.fd_prop      = fd_q;
    assign bus.bk_prop      = bk_q;
    assign bus.result_valid = rv_q;
    assign bus.result_err   = rerr_q;
    assign bus.epoch_done   = ed_q;
    assign bus.epoch_errors = eerr_q;
endmodule

// File: tb/tb_train_seq3.sv
// Scoreboard bench for train_seq3: network modelled as fout = fin ^ mask, random samples.
module tb_train_seq3;
    localparam int unsigned W  = 3;
    localparam int unsigned S  = 8;
    localparam int unsigned B  = 8;
    localparam int unsigned E  = 4;
    localparam int unsigned EW = $clog2(E + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] mask = '0;
    int ctrl_at = 0;

    train_seq3_if #(.WIDTH(W), .EPOCH_LEN(E)) bus ();

    train_seq3 #(
        .WIDTH(W), .SETTLE_CYCLES(S), .BK_CYCLES(B), .EPOCH_LEN(E)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.fout = bus.fin ^ mask;

    typedef struct {
        logic [W-1:0]  err;
        logic [W-1:0]  bin;
        int            bk;
        logic          ed;
        logic [EW-1:0] eerr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int m_done = 0;
    int m_err = 0;
    int m_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_expect(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [W-1:0] m, input bit ten, input int cat);
        exp_t e;
        bit trains;
        e.err  = (x ^ m) ^ y;
        e.bin  = ~e.err;
        trains = ten;
`ifdef TRAIN_SKIP_CORRECT_EN
        if (e.err == '0) trains = 1'b0;
`endif
        if (!trains) e.bk = 0;
        else if (cat >= 1 && cat <= int'(B)) e.bk = cat;
        else e.bk = B;
        m_done++;
        if (e.err != '0) m_err++;
        if (m_done == int'(E)) begin
            e.ed   = 1'b1;
            m_last = m_err;
            m_done = 0;
            m_err  = 0;
        end else begin
            e.ed = 1'b0;
        end
        e.eerr = EW'(m_last);
        sb.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] m,
                        input bit ten, input int cat, input bit abort);
        int n;
        @(negedge clk);
        bus.sample_x     = x;
        bus.sample_y     = y;
        bus.train_en     = ten;
        mask             = m;
        ctrl_at          = cat;
        bus.sample_valid = 1'b1;
        if (!abort) push_expect(x, y, m, ten, cat);
        n = 0;
        while (bus.sample_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: sample_ready stayed %b", bus.sample_ready);
        end
        @(posedge clk);
        #1 bus.sample_valid = 1'b0;
        if (abort) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("abort_fd", bus.fd_prop, 0);
            check("abort_bk", bus.bk_prop, 0);
            check("abort_rv", bus.result_valid, 0);
            @(negedge clk);
            rst    = 1'b0;
            m_done = 0;
            m_err  = 0;
            m_last = 0;
            @(posedge clk);
            #1;
            check("abort_ready", bus.sample_ready, 1);
            check("abort_eerr", bus.epoch_errors, 0);
        end else begin
            n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) begin
                total++;
                bad++;
                $display("FAIL result_timeout: %0d results outstanding", sb.size());
            end
        end
    endtask

    // Network side: pulse control_in on the ctrl_at-th bk_prop cycle, noise elsewhere.
    initial begin
        int bkc;
        bkc = 0;
        bus.control_in = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.bk_prop === 1'b1) begin
                bkc++;
                bus.control_in = (bkc == ctrl_at);
            end else begin
                bkc = 0;
                bus.control_in = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: measures phase lengths and checks each reported result against the queue.
    initial begin
        int fd_cnt, bk_cnt, gap;
        logic [W-1:0] bin_seen;
        exp_t e;
        fd_cnt = 0;
        bk_cnt = 0;
        gap = 0;
        bin_seen = '1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("fd_bk_excl", 32'(bus.fd_prop & bus.bk_prop), 0);
            if (bus.bk_prop !== 1'b1) check("bin_idle", bus.bin, 3'b111);
            if (bus.sample_ready === 1'b1) begin
                fd_cnt = 0;
                bk_cnt = 0;
                gap = 0;
            end
            if (bus.fd_prop === 1'b1) begin
                fd_cnt++;
                gap = 0;
            end else if (fd_cnt > 0) begin
                gap++;
            end
            if (bus.bk_prop === 1'b1) begin
                bk_cnt++;
                bin_seen = bus.bin;
            end
            if (bus.result_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: err=%b", bus.result_err);
                end else begin
                    e = sb.pop_front();
                    check("result_err", bus.result_err, e.err);
                    check("fd_len", fd_cnt, S);
                    check("bk_len", bk_cnt, e.bk);
                    check("report_gap", gap, e.bk + 1);
                    if (e.bk > 0) check("bin_bwd", bin_seen, e.bin);
                    check("epoch_done", bus.epoch_done, e.ed);
                    check("epoch_errors", bus.epoch_errors, e.eerr);
                end
            end else begin
                check("epoch_idle", bus.epoch_done, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_x     = '0;
        bus.sample_y     = '0;
        bus.train_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.sample_ready, 0);
        check("rst_fin", bus.fin, 0);
        check("rst_bin", bus.bin, 3'b111);
        check("rst_fd", bus.fd_prop, 0);
        check("rst_bk", bus.bk_prop, 0);
        check("rst_rv", bus.result_valid, 0);
        check("rst_rerr", bus.result_err, 0);
        check("rst_ed", bus.epoch_done, 0);
        check("rst_eerr", bus.epoch_errors, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_ready", bus.sample_ready, 1);
        check("rel_bin", bus.bin, 3'b111);
        check("rel_fd", bus.fd_prop, 0);
        check("rel_bk", bus.bk_prop, 0);

        // Epoch 1: correct, error 010, control pulse on 3rd BWD cycle, inference only.
        send(3'b111, 3'b111, 3'b000, 1'b1, 0, 1'b0);
        send(3'b111, 3'b111, 3'b010, 1'b1, 0, 1'b0);
        send(3'b111, 3'b111, 3'b010, 1'b1, 3, 1'b0);
        send(3'b111, 3'b111, 3'b111, 1'b0, 0, 1'b0);
        // Epoch 2: errors on samples 2 and 4.
        send(3'b010, 3'b010, 3'b000, 1'b1, 0, 1'b0);
        send(3'b010, 3'b010, 3'b001, 1'b1, 2, 1'b0);
        send(3'b101, 3'b101, 3'b000, 1'b0, 0, 1'b0);
        send(3'b101, 3'b101, 3'b100, 1'b1, 1, 1'b0);
        // One sample into epoch 3, then abort mid-forward.
        send(3'b001, 3'b110, 3'b000, 1'b1, 0, 1'b0);
        send(3'b011, 3'b011, 3'b000, 1'b1, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y, m;
            x = W'($urandom);
            y = ($urandom_range(0, 1) == 1) ? x : W'($urandom);
            m = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom);
            send(x, y, m, 1'($urandom_range(0, 1)), int'($urandom_range(0, B + 2)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
